// File: rtl/steering_ramp.sv
// Slew-limited steering command shaper: duty moves one LSB per STEP_DIV clocks, and a
// reversal brakes to zero, holds DEAD_CYCLES at zero, then flips the direction bit.
module steering_ramp #(
    parameter int COUNT_SIZE  = 4,
    parameter int STEP_DIV    = 16,
    parameter int DEAD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_in,
    output logic [31:0] cmd_out,
    output logic        busy,
    output logic        at_target
);
    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DW = $clog2(DEAD_CYCLES + 1) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RAMP, S_BRAKE, S_DEAD} state_t;

    state_t                r_state;
    logic                  r_tgt_soft;
    logic                  r_tgt_dir;
    logic [COUNT_SIZE-1:0] r_tgt_duty;
    logic                  r_soft_out;
    logic                  r_cur_dir;
    logic [COUNT_SIZE-1:0] r_cur_duty;
    logic [TW-1:0]         r_tick;
    logic [DW-1:0]         r_dead_cnt;

    state_t                w_state_nxt;
    logic                  w_dir_nxt;
    logic [COUNT_SIZE-1:0] w_duty_nxt;
    logic [DW-1:0]         w_dead_nxt;
    logic                  w_step;
    logic                  w_dir_mis;
    logic [COUNT_SIZE-1:0] w_duty_up;
    logic [COUNT_SIZE-1:0] w_duty_dn;
    logic                  w_unused;

    assign w_unused  = ^cmd_in[29:COUNT_SIZE];
    assign w_step    = (r_tick == TW'(STEP_DIV - 1));
    assign w_dir_mis = (r_tgt_dir != r_cur_dir);
    // Saturating neighbours of the current duty; the ramp never wraps.
    assign w_duty_up = (r_cur_duty == '1) ? r_cur_duty : r_cur_duty + COUNT_SIZE'(1);
    assign w_duty_dn = (r_cur_duty == '0) ? r_cur_duty : r_cur_duty - COUNT_SIZE'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_cur_dir;
        w_duty_nxt  = r_cur_duty;
        w_dead_nxt  = r_dead_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_dir_mis) begin
                    w_dead_nxt  = '0;
                    w_state_nxt = (r_cur_duty != '0) ? S_BRAKE : S_DEAD;
                end else if (r_cur_duty != r_tgt_duty) begin
                    w_state_nxt = S_RAMP;
                end
            end
            S_RAMP: begin
                if (w_dir_mis) begin
                    w_dead_nxt  = '0;
                    w_state_nxt = (r_cur_duty != '0) ? S_BRAKE : S_DEAD;
                end else if (r_cur_duty == r_tgt_duty) begin
                    w_state_nxt = S_IDLE;
                end else if (w_step) begin
                    w_duty_nxt = (r_cur_duty < r_tgt_duty) ? w_duty_up : w_duty_dn;
                    if (w_duty_nxt == r_tgt_duty) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_BRAKE: begin
                if (!w_dir_mis) begin
                    w_state_nxt = S_RAMP;
                end else if (r_cur_duty == '0) begin
                    w_dead_nxt  = '0;
                    w_state_nxt = S_DEAD;
                end else if (w_step) begin
                    w_duty_nxt = w_duty_dn;
                    if (w_duty_dn == '0) begin
                        w_dead_nxt  = '0;
                        w_state_nxt = S_DEAD;
                    end
                end
            end
            S_DEAD: begin
                w_duty_nxt = '0;
                // A target that returns to the current direction abandons the flip.
                if (!w_dir_mis) begin
                    w_dead_nxt  = '0;
                    w_state_nxt = (r_tgt_duty == '0) ? S_IDLE : S_RAMP;
                end else if (r_dead_cnt == DW'(DEAD_CYCLES)) begin
                    w_dir_nxt   = r_tgt_dir;
                    w_dead_nxt  = '0;
                    w_state_nxt = (r_tgt_duty == '0) ? S_IDLE : S_RAMP;
                end else begin
                    w_dead_nxt = r_dead_cnt + DW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_tgt_soft <= 1'b0;
            r_tgt_dir  <= 1'b0;
            r_tgt_duty <= '0;
            r_soft_out <= 1'b0;
            r_cur_dir  <= 1'b0;
            r_cur_duty <= '0;
            r_tick     <= '0;
            r_dead_cnt <= '0;
        end else begin
            r_tgt_soft <= cmd_in[31];
            r_tgt_dir  <= cmd_in[30];
            r_tgt_duty <= cmd_in[COUNT_SIZE-1:0];
            if (r_tgt_soft) begin
                r_soft_out <= 1'b1;
                r_state    <= S_IDLE;
                r_cur_dir  <= 1'b0;
                r_cur_duty <= '0;
                r_tick     <= '0;
                r_dead_cnt <= '0;
            end else begin
                r_soft_out <= 1'b0;
                r_state    <= w_state_nxt;
                r_cur_dir  <= w_dir_nxt;
                r_cur_duty <= w_duty_nxt;
                r_tick     <= w_step ? '0 : r_tick + TW'(1);
                r_dead_cnt <= w_dead_nxt;
            end
        end
    end

    assign cmd_out   = {r_soft_out, r_cur_dir, {(30 - COUNT_SIZE){1'b0}}, r_cur_duty};
    assign busy      = (r_state != S_IDLE);
    assign at_target = (r_state == S_IDLE) && !w_dir_mis && (r_cur_duty == r_tgt_duty);

endmodule

// File: tb/tb_steering_ramp.sv
// Bench for steering_ramp: directed table and corner sequences, then random commands
// checked against slew, step-spacing, dead-time and convergence rules.
module tb_steering_ramp;
    localparam int CS = 4;
    localparam int SD = 4;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cmd_in;
    logic [31:0] cmd_out;
    logic        busy;
    logic        at_target;

    steering_ramp #(.COUNT_SIZE(CS), .STEP_DIV(SD), .DEAD_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_in    (cmd_in),
        .cmd_out   (cmd_out),
        .busy      (busy),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_chk++;
        if (val < lo || val > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic apply(input logic [31:0] c);
        @(negedge clk);
        cmd_in = c;
    endtask

    // Waits for a fully settled output: exp on cmd_out, idle, and at target.
    task automatic settle(input string name, input logic [31:0] exp, input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clk);
            if (cmd_out === exp && busy === 1'b0 && at_target === 1'b1) ok = 1'b1;
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: cmd_out=0x%08h busy=%0b at_target=%0b, required 0x%08h idle at target within %0d clk",
                     name, cmd_out, busy, at_target, exp, bound);
        end
    endtask

    task automatic wait_for(input string name, input logic [31:0] exp, input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clk);
            if (cmd_out === exp) ok = 1'b1;
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: cmd_out=0x%08h, required 0x%08h within %0d clk", name, cmd_out, exp, bound);
        end
    endtask

    // Rule monitor: properties every legal output sequence must obey.
    bit          mon_en = 1'b0;
    bit          prev_vld;
    logic [31:0] prev_out;
    logic [31:0] samp;
    int          cyc = 0;
    int          last_chg;
    int          zero_run;
    int          dd;

    always @(posedge clk) samp <= cmd_in;

    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            prev_vld = 1'b0;
            last_chg = -1;
            zero_run = 0;
        end else begin
            check("reserved_bits_zero", 32'(cmd_out[29:CS]), 32'd0);
            check("busy_excludes_at_target", {31'd0, busy & at_target}, 32'd0);
            if (cmd_out[31]) begin
                check("soft_reset_out", cmd_out, 32'h8000_0000);
                last_chg = -1;
                zero_run = 0;
            end else begin
                if (at_target)
                    check("at_target_agrees", {27'd0, cmd_out[30], cmd_out[3:0]},
                          {27'd0, samp[30], samp[3:0]});
                if (prev_vld) begin
                    dd = int'(cmd_out[3:0]) - int'(prev_out[3:0]);
                    check("slew_one_lsb", {31'd0, (dd > 1 || dd < -1)}, 32'd0);
                    if (dd != 0) begin
                        if (last_chg >= 0) check_range("step_spacing", cyc - last_chg, SD, 100000);
                        last_chg = cyc;
                    end
                    if (cmd_out[30] != prev_out[30]) begin
                        check("flip_at_zero", {28'd0, cmd_out[3:0] | prev_out[3:0]}, 32'd0);
                        check_range("flip_dead_time", zero_run, DC, 100000);
                    end
                end
                if (cmd_out[3:0] != 4'd0) zero_run = 0;
                else if (prev_vld && !prev_out[31] && cmd_out[30] == prev_out[30]) zero_run++;
                else zero_run = 1;
            end
            prev_out = cmd_out;
            prev_vld = 1'b1;
        end
    end

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] exp;
        int          bound;
    } vec_t;

    vec_t        vt[6];
    logic [31:0] rc;
    int          h;
    int          zc;
    bit          dir1_seen;
    int          first_duty;
    logic [3:0]  seq[$];

    initial begin
        vt[0] = '{32'h0000_0008, 32'h0000_0008, 40};
        vt[1] = '{32'h4000_0004, 32'h4000_0004, 62};
        vt[2] = '{32'h0000_000F, 32'h0000_000F, 90};
        vt[3] = '{32'h4000_0000, 32'h4000_0000, 72};
        vt[4] = '{32'h7FFF_FFF3, 32'h4000_0003, 20};
        vt[5] = '{32'h0000_0000, 32'h0000_0000, 25};

        reset  = 1'b1;
        cmd_in = 32'hC000_000F;
        repeat (3) begin
            @(negedge clk);
            check("reset_cmd_out", cmd_out, 32'd0);
            check("reset_busy", {31'd0, busy}, 32'd0);
            check("reset_at_target", {31'd0, at_target}, 32'd1);
        end
        cmd_in = 32'd0;
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        foreach (vt[i]) begin
            apply(vt[i].cmd);
            settle($sformatf("table_%0d", i), vt[i].exp, vt[i].bound);
        end

        // Reversal from duty 8: ramp down, dead time at zero, flip, ramp to 4.
        apply(32'h0000_0008);
        settle("t3_pre", 32'h0000_0008, 40);
        apply(32'h4000_0004);
        zc = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (cmd_out == 32'd0) zc++;
            if (cmd_out == 32'h4000_0004 && !busy) break;
        end
        check_range("t3_dead_time", zc, DC, DC + 2);
        settle("t3_final", 32'h4000_0004, 4);

        // Reversal aborted during the dead time: direction must never flip.
        apply(32'h0000_0008);
        settle("t4_pre", 32'h0000_0008, 90);
        apply(32'h4000_0004);
        wait_for("t4_reach_zero", 32'h0000_0000, 60);
        @(negedge clk);
        cmd_in    = 32'h0000_0004;
        dir1_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cmd_out[30]) dir1_seen = 1'b1;
        end
        check("t4_no_flip", {31'd0, dir1_seen}, 32'd0);
        settle("t4_final", 32'h0000_0004, 4);

        // Soft reset mid-ramp, then restart from zero and saturate at 15.
        apply(32'h0000_000F);
        wait_for("t5_mid_ramp", 32'h0000_0007, 20);
        cmd_in = 32'h8000_000F;
        repeat (2) @(negedge clk);
        check("t5_soft_2clk", cmd_out, 32'h8000_0000);
        repeat (4) @(negedge clk);
        check("t5_soft_held", cmd_out, 32'h8000_0000);
        cmd_in     = 32'h0000_000F;
        first_duty = -1;
        for (int k = 0; k < 80 && first_duty < 0; k++) begin
            @(negedge clk);
            if (!cmd_out[31] && cmd_out[3:0] != 4'd0) first_duty = int'(cmd_out[3:0]);
        end
        check_range("t5_restart_from_zero", first_duty, 1, 1);
        settle("t5_reach_15", 32'h0000_000F, 70);
        repeat (30) @(negedge clk);
        check("t5_no_wrap", cmd_out, 32'h0000_000F);

        // Target lowered mid-ramp: reverse the step sign at the next step.
        apply(32'h0000_0000);
        settle("t6_pre", 32'h0000_0000, 70);
        apply(32'h0000_0008);
        wait_for("t6_reach_5", 32'h0000_0005, 30);
        cmd_in = 32'h0000_0002;
        seq.delete();
        seq.push_back(cmd_out[3:0]);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cmd_out[3:0] != seq[$]) seq.push_back(cmd_out[3:0]);
            if (!busy && at_target) break;
        end
        check_range("t6_seq_len", seq.size(), 4, 4);
        if (seq.size() == 4)
            check("t6_seq", {16'd0, seq[0], seq[1], seq[2], seq[3]}, 32'h0000_5432);
        check("t6_final", cmd_out, 32'h0000_0002);

        // Random commands; the rule monitor runs throughout.
        for (int i = 0; i < 150; i++) begin
            rc     = $urandom;
            rc[31] = ($urandom_range(0, 9) == 0);
            apply(rc);
            if (!rc[31] && $urandom_range(0, 2) == 0) begin
                settle($sformatf("rand_settle_%0d", i), {1'b0, rc[30], 26'd0, rc[3:0]}, 140);
            end else begin
                h = $urandom_range(1, 40);
                repeat (h) @(negedge clk);
            end
        end
        apply(32'h0000_0006);
        settle("rand_final", 32'h0000_0006, 140);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
